// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction fetch front end with a small prefetch FIFO. A fetch PC streams
// word-aligned read requests to an instruction memory that answers exactly one
// cycle later. Each answer is pushed, together with its PC+4 tag, into a FIFO
// that decode drains from the head. Decode can redirect the fetch stream, which
// flushes the FIFO and drops the response still in flight.
//
// Optional feature (macro FETCH_BYPASS_EN):
//   When defined, a response arriving while the FIFO is empty is presented at
//   the head in the same cycle; if decode takes it, it is never written.
//   When undefined, outputs come only from registers (no IM_rdata->output path).
//
// Parameters:
//   ADDR_W   - width of PC / IM_addr / ID_new_PC / IF_PC4
//   DEPTH    - FIFO entries (power of two, >= 2)
//   RESET_PC - first fetch address after reset
//
// Ports:
//   Clk            in   clock, rising edge
//   Reset          in   asynchronous, active-low reset
//   ID_PCSrc       in   redirect request from decode
//   ID_new_PC      in   redirect target
//   ID_stall       in   decode not ready; blocks a pop
//   IM_req         out  instruction memory read strobe
//   IM_addr        out  read address (word aligned)
//   IM_rdata       in   read data, valid one cycle after IM_req
//   IF_valid       out  head entry valid
//   IF_Instruction out  head instruction (0 when not valid)
//   IF_PC4         out  head instruction address + 4 (0 when not valid)
//   IF_count       out  number of occupied FIFO entries
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     ID_PCSrc,
    input  logic [ADDR_W-1:0]        ID_new_PC,
    input  logic                     ID_stall,
    output logic                     IM_req,
    output logic [ADDR_W-1:0]        IM_addr,
    input  logic [31:0]              IM_rdata,
    output logic                     IF_valid,
    output logic [31:0]              IF_Instruction,
    output logic [ADDR_W-1:0]        IF_PC4,
    output logic [$clog2(DEPTH):0]   IF_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    logic [ADDR_W-1:0] r_pc;
    logic              r_inFlight;
    logic [ADDR_W-1:0] r_tag;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_instrMem [DEPTH];
    logic [ADDR_W-1:0] r_pc4Mem   [DEPTH];

    logic [CNT_W-1:0]  w_occupancy;
    logic              w_req;
    logic              w_qValid;
    logic              w_respValid;
    logic              w_push;
    logic              w_pop;
    logic              w_headValid;
    logic [31:0]       w_headInstr;
    logic [ADDR_W-1:0] w_headPc4;

    // Credit check counts the in-flight word as already occupying a slot, so
    // a request can never overflow the FIFO. A freed slot only shows up in
    // r_count the cycle after its pop, which is when the next request issues.
    // A response that lands during a redirect is dropped (killed).
    always_comb begin
        w_occupancy = r_count + CNT_W'(r_inFlight);
        w_req       = Reset & ~ID_PCSrc & (w_occupancy < CNT_W'(DEPTH));
        w_qValid    = (r_count != '0);
        w_respValid = r_inFlight & ~ID_PCSrc;
        w_pop       = w_qValid & ~ID_stall & ~ID_PCSrc;
`ifdef FETCH_BYPASS_EN
        w_headValid = w_qValid | w_respValid;
        w_headInstr = w_qValid ? r_instrMem[r_rdPtr] : IM_rdata;
        w_headPc4   = w_qValid ? r_pc4Mem[r_rdPtr]   : r_tag;
        w_push      = w_respValid & ~(~w_qValid & ~ID_stall);
`else
        w_headValid = w_qValid;
        w_headInstr = r_instrMem[r_rdPtr];
        w_headPc4   = r_pc4Mem[r_rdPtr];
        w_push      = w_respValid;
`endif
    end

    // Output drive: head fields are forced to zero whenever nothing is valid.
    always_comb begin
        IM_req         = w_req;
        IM_addr        = r_pc;
        IF_valid       = w_headValid;
        IF_Instruction = w_headValid ? w_headInstr : 32'd0;
        IF_PC4         = w_headValid ? w_headPc4 : '0;
        IF_count       = r_count;
    end

    // Fetch PC, in-flight tracking and FIFO bookkeeping. A redirect wins over
    // any same-cycle push or pop: the FIFO is emptied and the in-flight word
    // is forgotten, and since IM_req is low that cycle nothing new is pending.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc       <= RESET_PC & ALIGN_MASK;
            r_inFlight <= 1'b0;
            r_tag      <= '0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
        end else if (ID_PCSrc) begin
            r_pc       <= ID_new_PC & ALIGN_MASK;
            r_inFlight <= 1'b0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
        end else begin
            r_inFlight <= w_req;
            if (w_req) begin
                r_pc  <= r_pc + PC_STEP;
                r_tag <= r_pc + PC_STEP;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage has no reset; entries are only visible through r_count.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= IM_rdata;
            r_pc4Mem[r_wrPtr]   <= r_tag;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_unit
//
// Directed bench for fetch_queue_unit (default parameters). A table of
// per-cycle vectors covers reset release, stall saturation and drain; short
// hand-written sequences cover redirect latency, PC wrap and mid-fetch reset.
// Expected values follow the build: FETCH_BYPASS_EN changes the first-valid
// timing.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;

   logic        Clk;
   logic        Reset;
   logic        ID_PCSrc;
   logic [31:0] ID_new_PC;
   logic        ID_stall;
   logic        IM_req;
   logic [31:0] IM_addr;
   logic [31:0] IM_rdata;
   logic        IF_valid;
   logic [31:0] IF_Instruction;
   logic [31:0] IF_PC4;
   logic [2:0]  IF_count;

`ifdef FETCH_BYPASS_EN
   localparam int REDIR_LAT = 2;
`else
   localparam int REDIR_LAT = 3;
`endif

   typedef struct {
      logic        stall;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc4;
      logic [2:0]  expCount;
   } vec_t;

   vec_t        vecs [16];
   int          compared;
   int          mismatched;
   logic        prevReq;
   logic [31:0] prevAddr;
   logic        sReq;
   logic [31:0] sAddr;
   logic        sValid;
   logic [31:0] sInstr;
   logic [31:0] sPc4;
   logic [2:0]  sCount;

   fetch_queue_unit dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .ID_PCSrc       (ID_PCSrc),
      .ID_new_PC      (ID_new_PC),
      .ID_stall       (ID_stall),
      .IM_req         (IM_req),
      .IM_addr        (IM_addr),
      .IM_rdata       (IM_rdata),
      .IF_valid       (IF_valid),
      .IF_Instruction (IF_Instruction),
      .IF_PC4         (IF_PC4),
      .IF_count       (IF_count)
   );

   // Free-running 10-unit clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Instruction word the memory model returns for a given address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs and the memory answer to last cycle's
   // request just after the rising edge, sample outputs on the falling edge.
   task automatic applyStimulus(input logic pcsrc, input logic [31:0] newPc, input logic stall);
      ID_PCSrc  = pcsrc;
      ID_new_PC = newPc;
      ID_stall  = stall;
      IM_rdata  = prevReq ? memWord(prevAddr) : 32'hBAD0_BAD0;
      @(negedge Clk);
      sReq     = IM_req;
      sAddr    = IM_addr;
      sValid   = IF_valid;
      sInstr   = IF_Instruction;
      sPc4     = IF_PC4;
      sCount   = IF_count;
      prevReq  = IM_req;
      prevAddr = IM_addr;
      @(posedge Clk);
      #1;
   endtask

   task automatic setVec(input int i, input logic st, input logic rq, input logic [31:0] ad,
                         input logic vl, input logic [31:0] p4, input logic [2:0] ct);
      vecs[i].stall    = st;
      vecs[i].expReq   = rq;
      vecs[i].expAddr  = ad;
      vecs[i].expValid = vl;
      vecs[i].expPc4   = p4;
      vecs[i].expCount = ct;
   endtask

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   // Main test sequence.
   initial begin
      logic [31:0] firstPc4;
      logic [31:0] firstInstr;
      logic [31:0] addrSeen [3];
      logic [31:0] pc4Seen [3];
      int          firstLat;
      int          nA;
      int          nP;

      compared   = 0;
      mismatched = 0;
      prevReq    = 1'b0;
      prevAddr   = '0;
      Reset      = 1'b0;
      ID_PCSrc   = 1'b0;
      ID_new_PC  = '0;
      ID_stall   = 1'b0;
      IM_rdata   = '0;

      // Reset release with stall held: fill to 4, then drain and resume.
      setVec(0,  1, 1, 32'h00, 0, 32'h00, 0);
`ifdef FETCH_BYPASS_EN
      setVec(1,  1, 1, 32'h04, 1, 32'h04, 0);
`else
      setVec(1,  1, 1, 32'h04, 0, 32'h00, 0);
`endif
      setVec(2,  1, 1, 32'h08, 1, 32'h04, 1);
      setVec(3,  1, 1, 32'h0C, 1, 32'h04, 2);
      setVec(4,  1, 0, 32'h00, 1, 32'h04, 3);
      setVec(5,  1, 0, 32'h00, 1, 32'h04, 4);
      setVec(6,  1, 0, 32'h00, 1, 32'h04, 4);
      setVec(7,  1, 0, 32'h00, 1, 32'h04, 4);
      setVec(8,  1, 0, 32'h00, 1, 32'h04, 4);
      setVec(9,  1, 0, 32'h00, 1, 32'h04, 4);
      setVec(10, 0, 0, 32'h00, 1, 32'h04, 4);
      setVec(11, 0, 1, 32'h10, 1, 32'h08, 3);
      setVec(12, 0, 1, 32'h14, 1, 32'h0C, 2);
      setVec(13, 0, 1, 32'h18, 1, 32'h10, 2);
      setVec(14, 0, 1, 32'h1C, 1, 32'h14, 2);
      setVec(15, 0, 1, 32'h20, 1, 32'h18, 2);

      repeat (2) @(posedge Clk);
      #1;
      checkOutput("reset.valid", IF_valid, 0);
      checkOutput("reset.count", IF_count, 0);
      checkOutput("reset.req",   IM_req, 0);
      checkOutput("reset.instr", IF_Instruction, 0);
      checkOutput("reset.pc4",   IF_PC4, 0);

      Reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 32'h0, vecs[i].stall);
         checkOutput($sformatf("vec%0d.req", i),   sReq,   vecs[i].expReq);
         if (vecs[i].expReq)
            checkOutput($sformatf("vec%0d.addr", i), sAddr, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d.valid", i), sValid, vecs[i].expValid);
         checkOutput($sformatf("vec%0d.pc4", i),   sPc4,   vecs[i].expPc4);
         checkOutput($sformatf("vec%0d.instr", i), sInstr,
                     vecs[i].expValid ? memWord(vecs[i].expPc4 - 32'd4) : 32'd0);
         checkOutput($sformatf("vec%0d.count", i), sCount, vecs[i].expCount);
      end

      // Redirect to 0x103 with three queued and one in flight.
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h103, 1'b0);
      checkOutput("redir.countBefore", sCount, 3);
      checkOutput("redir.reqLow",      sReq, 0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("redir.countAfter", sCount, 0);
      checkOutput("redir.req",        sReq, 1);
      checkOutput("redir.addr",       sAddr, 32'h100);
      checkOutput("redir.validN1",    sValid, 0);
      firstLat   = 0;
      firstPc4   = 32'h1;
      firstInstr = 32'h1;
      for (int k = 2; k <= 7; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         if (sValid && firstLat == 0) begin
            firstLat   = k;
            firstPc4   = sPc4;
            firstInstr = sInstr;
         end
      end
      checkOutput("redir.latency",    firstLat, REDIR_LAT);
      checkOutput("redir.firstPc4",   firstPc4, 32'h104);
      checkOutput("redir.firstInstr", firstInstr, memWord(32'h100));

      // PC wrap across the top of the address space.
      applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0);
      nA = 0;
      nP = 0;
      firstInstr = 32'h1;
      for (int j = 0; j < 3; j++) begin
         addrSeen[j] = 32'h1;
         pc4Seen[j]  = 32'h1;
      end
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         if (sReq && nA < 3) begin
            addrSeen[nA] = sAddr;
            nA++;
         end
         if (sValid && nP < 3) begin
            if (nP == 0) firstInstr = sInstr;
            pc4Seen[nP] = sPc4;
            nP++;
         end
      end
      checkOutput("wrap.addr0", addrSeen[0], 32'hFFFF_FFF8);
      checkOutput("wrap.addr1", addrSeen[1], 32'hFFFF_FFFC);
      checkOutput("wrap.addr2", addrSeen[2], 32'h0000_0000);
      checkOutput("wrap.pc4_0", pc4Seen[0],  32'hFFFF_FFFC);
      checkOutput("wrap.pc4_1", pc4Seen[1],  32'h0000_0000);
      checkOutput("wrap.pc4_2", pc4Seen[2],  32'h0000_0004);
      checkOutput("wrap.instr0", firstInstr, memWord(32'hFFFF_FFF8));

      // Reset pulled low with two queued and one in flight.
      applyStimulus(1'b1, 32'h200, 1'b1);
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
      #1;
      checkOutput("midrst.countBefore", IF_count, 2);
      Reset = 1'b0;
      #1;
      checkOutput("midrst.valid", IF_valid, 0);
      checkOutput("midrst.count", IF_count, 0);
      checkOutput("midrst.req",   IM_req, 0);
      checkOutput("midrst.instr", IF_Instruction, 0);
      checkOutput("midrst.pc4",   IF_PC4, 0);
      prevReq = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("rel.req",   sReq, 1);
      checkOutput("rel.addr",  sAddr, 32'h0);
      checkOutput("rel.valid", sValid, 0);
      checkOutput("rel.count", sCount, 0);
      firstPc4   = 32'h1;
      firstInstr = 32'h1;
      firstLat   = 0;
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         if (sValid && firstLat == 0) begin
            firstLat   = k;
            firstPc4   = sPc4;
            firstInstr = sInstr;
         end
      end
      checkOutput("rel.firstPc4",   firstPc4, 32'h4);
      checkOutput("rel.firstInstr", firstInstr, memWord(32'h0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
